// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST controller.
package sram_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [2:0] elem_idx_t;

  localparam elem_idx_t LAST_ELEM = 3'd5;

  // Backgrounds are one bit: 0 selects all-zeros, 1 selects all-ones.
  typedef struct packed {
    logic down;
    logic has_rd;
    logic rd_bg;
    logic has_wr;
    logic wr_bg;
  } elem_t;

  localparam elem_t ELEM_TBL [6] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // 0 up   (w0)
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},  // 1 up   (r0,w1)
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // 2 up   (r1,w0)
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},  // 3 down (r0,w1)
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 4 down (r1,w0)
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}   // 5 up   (r0)
  };

endpackage

// File: rtl/sramSpw2048d16.sv
// Behavioural 2048x16 single-port SRAM wrapper; read data registered one cycle after me=1, we=0.
module sramSpw2048d16 (
  input  logic        clk,
  input  logic        me,
  input  logic        we,
  input  logic [10:0] adr,
  input  logic [15:0] d,
  output logic [15:0] q
);

  logic [15:0] mem_q [2048];

  // Single-port array access: write or registered read.
  always_ff @(posedge clk) begin
    if (me) begin
      if (we) begin
        mem_q[adr] <= d;
      end else begin
        q <= mem_q[adr];
      end
    end
  end

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller: one SRAM access per cycle, stops at the first mismatching read.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [DATA_W-1:0] sram_d,
  output logic              sram_we,
  output logic              sram_me,
  input  logic [DATA_W-1:0] sram_q
);

  localparam logic [ADDR_W-1:0] ADR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADR_ONES = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic              busy_q, done_q, fail_q;
  elem_idx_t         elem_q, pend_elem_q, fail_elem_q;
  logic [ADDR_W-1:0] adr_q, pend_adr_q, fail_adr_q;
  logic [DATA_W-1:0] d_q, fail_exp_q, fail_got_q;
  logic              me_q, we_q, phase_q, pend_q, fin_q;

  logic [DATA_W-1:0] exp_s, nxt_d_s;
  logic              mismatch_s, cur_down_s, last_adr_s, last_acc_s;
  logic              nxt_phase_s, nxt_we_s;
  elem_idx_t         nxt_elem_s;
  logic [ADDR_W-1:0] nxt_adr_s;

  // Compare the pending read and work out the access that follows the one on the bus.
  always_comb begin
    exp_s       = {DATA_W{ELEM_TBL[pend_elem_q].rd_bg}};
    mismatch_s  = (state_q == RUN) && pend_q && (sram_q != exp_s);
    cur_down_s  = ELEM_TBL[elem_q].down;
    last_adr_s  = cur_down_s ? (adr_q == ADR_ZERO) : (adr_q == ADR_ONES);
    nxt_elem_s  = elem_q;
    nxt_adr_s   = adr_q;
    nxt_phase_s = 1'b0;
    last_acc_s  = 1'b0;
    if (ELEM_TBL[elem_q].has_rd && ELEM_TBL[elem_q].has_wr && !phase_q) begin
      nxt_phase_s = 1'b1;
    end else if (!last_adr_s) begin
      nxt_adr_s = cur_down_s ? (adr_q - ADR_ONE) : (adr_q + ADR_ONE);
    end else if (elem_q != LAST_ELEM) begin
      nxt_elem_s = elem_q + 3'd1;
      nxt_adr_s  = ELEM_TBL[nxt_elem_s].down ? ADR_ONES : ADR_ZERO;
    end else begin
      last_acc_s = 1'b1;
    end
    nxt_we_s = nxt_phase_s | ~ELEM_TBL[nxt_elem_s].has_rd;
    if (nxt_we_s) begin
      nxt_d_s = {DATA_W{ELEM_TBL[nxt_elem_s].wr_bg}};
    end else begin
      nxt_d_s = d_q;
    end
  end

  // Controller state machine with registered SRAM and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      elem_q      <= 3'd0;
      pend_elem_q <= 3'd0;
      fail_elem_q <= 3'd0;
      adr_q       <= ADR_ZERO;
      pend_adr_q  <= ADR_ZERO;
      fail_adr_q  <= ADR_ZERO;
      d_q         <= {DATA_W{1'b0}};
      fail_exp_q  <= {DATA_W{1'b0}};
      fail_got_q  <= {DATA_W{1'b0}};
      me_q        <= 1'b0;
      we_q        <= 1'b0;
      phase_q     <= 1'b0;
      pend_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_elem_q <= 3'd0;
            fail_adr_q  <= ADR_ZERO;
            fail_exp_q  <= {DATA_W{1'b0}};
            fail_got_q  <= {DATA_W{1'b0}};
            elem_q      <= 3'd0;
            adr_q       <= ADR_ZERO;
            d_q         <= {DATA_W{ELEM_TBL[0].wr_bg}};
            phase_q     <= 1'b0;
            me_q        <= 1'b1;
            we_q        <= 1'b1;
            pend_q      <= 1'b0;
            fin_q       <= 1'b0;
          end else begin
            me_q <= 1'b0;
            we_q <= 1'b0;
          end
        end
        RUN: begin
          pend_q      <= me_q & ~we_q;
          pend_adr_q  <= adr_q;
          pend_elem_q <= elem_q;
          if (mismatch_s) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            fail_q      <= 1'b1;
            fail_elem_q <= pend_elem_q;
            fail_adr_q  <= pend_adr_q;
            fail_exp_q  <= exp_s;
            fail_got_q  <= sram_q;
            me_q        <= 1'b0;
            we_q        <= 1'b0;
          end else if (fin_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            me_q    <= 1'b0;
            we_q    <= 1'b0;
          end else if (last_acc_s) begin
            // Final read is on the bus; its compare needs one more cycle in RUN.
            me_q  <= 1'b0;
            we_q  <= 1'b0;
            fin_q <= 1'b1;
          end else begin
            elem_q  <= nxt_elem_s;
            adr_q   <= nxt_adr_s;
            phase_q <= nxt_phase_s;
            we_q    <= nxt_we_s;
            d_q     <= nxt_d_s;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          me_q    <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  // A mismatch kills the access in flight, so the faulty word is never overwritten.
  assign sram_me   = me_q & ~mismatch_s;
  assign sram_we   = we_q & ~mismatch_s;
  assign sram_adr  = adr_q;
  assign sram_d    = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_elem = fail_elem_q;
  assign fail_adr  = fail_adr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_got  = fail_got_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench: SRAM wrapper behind a stuck-at shim, March C- reference model, access-order monitor.
module tb_sram_march_bist;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int NW    = 2048;
  localparam int TOTAL = NW * 10;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic          busy, done, fail, sram_we, sram_me;
  logic [2:0]    fail_elem;
  logic [AW-1:0] fail_adr, sram_adr, last_rd_adr, fault_adr;
  logic [DW-1:0] fail_exp, fail_got, sram_d, sram_q, q_raw;
  logic [3:0]    fault_bit;
  bit            fault_en, fault_val;
  int            n_chk = 0;
  int            n_bad = 0;
  int            mon_cnt, seq_err;
  logic [DW-1:0] model_mem [NW];

  always #5 clk = ~clk;

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_elem(fail_elem), .fail_adr(fail_adr), .fail_exp(fail_exp), .fail_got(fail_got),
    .sram_adr(sram_adr), .sram_d(sram_d), .sram_we(sram_we), .sram_me(sram_me), .sram_q(sram_q)
  );

  sramSpw2048d16 u_sram (
    .clk(clk), .me(sram_me), .we(sram_we), .adr(sram_adr), .d(sram_d), .q(q_raw)
  );

  // Fault shim: the selected cell reads back with one bit stuck.
  always @(posedge clk) if (sram_me && !sram_we) last_rd_adr <= sram_adr;

  always_comb begin
    sram_q = q_raw;
    if (fault_en && last_rd_adr == fault_adr) sram_q[fault_bit] = fault_val;
  end

  // Expected n-th access of March C-, derived arithmetically from the element list.
  function automatic bit acc_ok(input int n);
    int e, i, j;
    logic [AW-1:0] a;
    bit w;
    logic [DW-1:0] dv;
    if (n >= TOTAL) return 1'b0;
    if (n < NW) begin
      e = 0; i = n; w = 1'b1;
    end else if (n < 9 * NW) begin
      j = n - NW;
      e = 1 + j / (2 * NW);
      i = (j % (2 * NW)) / 2;
      w = (j % 2) == 1;
    end else begin
      e = 5; i = n - 9 * NW; w = 1'b0;
    end
    a  = (e == 3 || e == 4) ? AW'(NW - 1 - i) : AW'(i);
    dv = (e % 2 == 1) ? 16'hFFFF : 16'h0000;
    return (sram_adr == a) && (sram_we == w) && (!w || sram_d == dv);
  endfunction

  always @(negedge clk) begin
    if (sram_me) begin
      mon_cnt <= mon_cnt + 1;
      if (!acc_ok(mon_cnt)) seq_err <= seq_err + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: run March C- over an array with the stuck bit applied on read.
  task automatic model_run(output bit mf, output int melem, output int madr, output int mexp,
                           output int mgot, output int medge, output int mcnt);
    int n, a;
    logic [DW-1:0] v, rb;
    mf = 1'b0; melem = 0; madr = 0; mexp = 0; mgot = 0; medge = 0; n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < NW; i++) begin
        a = (e == 3 || e == 4) ? NW - 1 - i : i;
        if (e != 0) begin
          rb = (e % 2 == 0) ? 16'hFFFF : 16'h0000;
          v  = model_mem[a];
          if (fault_en && a == int'(fault_adr)) v[fault_bit] = fault_val;
          if (v != rb) begin
            mf = 1'b1; melem = e; madr = a; mexp = int'(rb); mgot = int'(v);
            medge = n + 2; mcnt = n + 1;
            return;
          end
          medge = n + 2;
          n++;
        end
        if (e != 5) begin
          model_mem[a] = (e % 2 == 1) ? 16'hFFFF : 16'h0000;
          n++;
        end
      end
    end
    mcnt = n;
  endtask

  task automatic run_test(input string tag, input bit fen, input logic [AW-1:0] fadr,
                          input logic [3:0] fbit, input bit fval, input int extra);
    bit mf;
    int melem, madr, mexp, mgot, medge, mcnt, n;
    fault_en = fen; fault_adr = fadr; fault_bit = fbit; fault_val = fval;
    model_run(mf, melem, madr, mexp, mgot, medge, mcnt);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mon_cnt = 0; seq_err = 0;
    check({tag, "_start_ctl"}, {busy, done, fail}, 3'b100);
    check({tag, "_start_fail"}, {fail_elem, fail_adr, fail_exp, fail_got}, 64'd0);
    n = 0;
    while (!done && n < 25000) begin
      @(posedge clk); n++; #1;
      start = (n + 1 == extra);
    end
    start = 1'b0;
    check({tag, "_done_edge"}, n, medge);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_fail"}, fail, mf);
    check({tag, "_elem"}, fail_elem, melem);
    check({tag, "_adr"}, fail_adr, madr);
    check({tag, "_exp"}, fail_exp, mexp);
    check({tag, "_got"}, fail_got, mgot);
    check({tag, "_me_count"}, mon_cnt, mcnt);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_bus_off"}, {sram_me, sram_we}, 2'b00);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fault_en = 1'b0; fault_adr = '0; fault_bit = 4'd0;
    fault_val = 1'b0; mon_cnt = 0; seq_err = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {busy, done, fail, sram_me, sram_we}, 5'd0);
    check("rst_bus", {sram_adr, sram_d}, 64'd0);
    check("rst_fail", {fail_elem, fail_adr, fail_exp, fail_got}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_access", mon_cnt, 0);

    // Abort a run with reset at cycle 5000.
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4999) @(posedge clk);
    #3;
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {busy, done, fail, sram_me, sram_we}, 5'd0);
    check("mid_rst_bus", {sram_adr, sram_d}, 64'd0);
    check("mid_rst_fail", {fail_elem, fail_adr, fail_exp, fail_got}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mon_cnt = 0;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle", mon_cnt, 0);

    run_test("pass_ign_start", 1'b0, 11'h000, 4'd0, 1'b0, 100);
    run_test("pass_b2b", 1'b0, 11'h000, 4'd0, 1'b0, 0);
    run_test("sa1_155", 1'b1, 11'h155, 4'd3, 1'b1, 0);
    run_test("sa0_7ff", 1'b1, 11'h7FF, 4'd0, 1'b0, 0);
    for (int r = 0; r < 2; r++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_test("rand", 1'b1, AW'($urandom_range(0, NW - 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 SHALL have parameters: ADDR_W, default 11, SRAM address width (2048 words).
REQ-002 SHALL have parameter DATA_W, default 16, SRAM word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as the codebase names them: clk and rst_n.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  pulse; begin test
- busy  out  1  test in progress
- done  out  1  test finished; sticky until next accepted start
- fail  out  1  mismatch found; valid when done
- fail_elem  out  3  march element index of first failure
- fail_adr  out  ADDR_W  address of first failure
- fail_exp  out  DATA_W  expected word
- fail_got  out  DATA_W  read word
- sram_adr  out  ADDR_W  SRAM address
- sram_d  out  DATA_W  SRAM write data
- sram_we  out  1  SRAM write enable
- sram_me  out  1  SRAM memory enable
- sram_q  in  DATA_W  SRAM read data, valid the cycle after a read (me=1, we=0)

Function
REQ-005 SHALL run March C- with backgrounds B0=all-zeros, B1=all-ones, as elements 0..5: 0 up(w B0); 1 up(r B0,w B1); 2 up(r B1,w B0); 3 down(r B0,w B1); 4 down(r B1,w B0); 5 up(r B0).
REQ-006 Up order SHALL be 0..2^ADDR_W-1; down order SHALL be 2^ADDR_W-1..0; the address counter SHALL wrap only at element boundaries.
REQ-007 Exactly one SRAM access SHALL issue per cycle while busy, with no idle cycles between elements; total accesses = 2^ADDR_W*10 (20480 at defaults).
REQ-008 In read/write elements, the read of address A SHALL issue in cycle N and the write of A in cycle N+1.
REQ-009 sram_q SHALL be compared combinationally against the expected background in the cycle after each read.
REQ-010 State machine SHALL be IDLE -> RUN (start) -> DONE (last compare passes, or any mismatch), DONE -> RUN (start).
REQ-011 start SHALL be sampled only in IDLE or DONE and ignored in RUN.
REQ-012 The first access (element 0, address 0, write) SHALL be presented in the cycle immediately after start is sampled high.
REQ-013 Accepting start SHALL clear done, fail and all fail_* outputs.
REQ-014 On mismatch, the controller SHALL:
- drive sram_me=0 in that same cycle, suppressing the pending write;
- capture fail_elem, fail_adr, fail_exp, fail_got;
- enter DONE at the next edge with fail=1.
REQ-015 With no mismatch, done SHALL rise and busy fall 2^ADDR_W*10+1 edges after the start edge, with fail=0.
REQ-016 sram_me, sram_we SHALL be 0 whenever not in RUN; sram_adr and sram_d SHALL hold their last value.
REQ-017 busy SHALL be registered and equal (state==RUN).

Reset
REQ-018 On rst_n low, at any time including mid-test:
- state SHALL be IDLE;
- busy, done, fail, sram_me, sram_we SHALL be 0;
- sram_adr, sram_d, fail_elem, fail_adr, fail_exp, fail_got SHALL be 0.
REQ-019 After reset release, no SRAM access SHALL occur until start is sampled.

Structure
REQ-020 Package sram_bist_pkg SHALL hold the state enum (IDLE, RUN, DONE), the element index type, and the element table (direction, read background, write background, has-write flag).
REQ-021 No sub-module is required. The testbench SHALL wrap the team's 2048x16 single-port SRAM wrapper, sramSpw2048d16, with a fault-injection shim.

Verification
REQ-022 Fault-free SRAM, start pulse: done rises at edge 20481 after start, fail=0, exactly 20480 me-high cycles.
REQ-023 Bit 3 of address 0x155 stuck-at-1: fail=1, fail_elem=1, fail_adr=0x155, fail_exp=0x0000, fail_got=0x0008, and no write to 0x155 in the cycle after that read.
REQ-024 Bit 0 of address 0x7FF stuck-at-0: fail_elem=2, fail_adr=0x000? no -- element 2 runs upward, so the first fault read is at address 0x7FF: fail_adr=0x7FF, fail_exp=0xFFFF, fail_got=0xFFFE.
REQ-025 start pulsed during RUN at cycle 100: ignored; completion timing is unchanged from REQ-022.
REQ-026 rst_n driven low at cycle 5000 of a run: outputs follow REQ-018 asynchronously; a later start completes with timing per REQ-022.
REQ-027 Two back-to-back runs (start in DONE): done and fail clear on the start edge; the second run passes identically.
